// File: rtl/mem_responder_if.sv
// Request/response handshake bundle between an initiator and mem_responder.
// Ports: req_valid/req_ready/req_write/req_addr/req_wdata (initiator -> responder),
//        resp_valid/resp_ready/resp_rdata/resp_err (responder -> initiator), busy (status).
interface mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err, busy
  );
endinterface

// File: rtl/mem_responder.sv
// Single-outstanding word memory responder: one request, fixed wait, one response.
// Latency: response valid LATENCY edges after the accept edge (counting it as edge 1: LATENCY+1).
// Backpressure: resp held stable while resp_ready=0; req_ready only in IDLE (one bubble per txn).
// Ports: clk, rst (sync, active-high), io_bus (mem_responder_if.slave: req_*, resp_*, busy).
module mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic           clk,
  input  logic           rst,
  mem_responder_if.slave io_bus
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [3:0]        r_cnt;
  logic              r_write;
  logic [31:0]       r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic              r_err;
  logic [31:0]       r_mem [DEPTH_WORDS];
  // A word reads as zero until first written after reset, so clearing storage
  // only needs this vector rather than every data word.
  logic [DEPTH_WORDS-1:0] r_wvld;

  logic              w_accept;
  logic              w_enter_resp;
  logic              w_op_write;
  logic [31:0]       w_op_addr;
  logic [31:0]       w_op_wdata;
  logic [AW-1:0]     w_idx;
  logic              w_err;
  logic              w_we;
  logic [31:0]       w_rd_word;

  assign w_accept     = io_bus.req_valid && (r_state == S_IDLE);
  assign w_enter_resp = (w_accept && (LATENCY == 0)) || ((r_state == S_WAIT) && (r_cnt == 4'd0));

  // With zero latency RESP is entered on the accept edge itself, before the
  // captured registers hold the request, so the live inputs are used there.
  assign w_op_write = (r_state == S_IDLE) ? io_bus.req_write : r_write;
  assign w_op_addr  = (r_state == S_IDLE) ? io_bus.req_addr  : r_addr;
  assign w_op_wdata = (r_state == S_IDLE) ? io_bus.req_wdata : r_wdata;

  assign w_idx     = w_op_addr[AW+1:2];
  assign w_err     = (w_op_addr[1:0] != 2'b00) || (w_op_addr[31:AW+2] != '0);
  assign w_we      = w_enter_resp && w_op_write && !w_err;
  assign w_rd_word = r_wvld[w_idx] ? r_mem[w_idx] : 32'd0;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (io_bus.req_valid) w_next = (LATENCY == 0) ? S_RESP : S_WAIT;
      S_WAIT:  if (r_cnt == 4'd0) w_next = S_RESP;
      S_RESP:  if (io_bus.resp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    io_bus.req_ready  = (r_state == S_IDLE);
    io_bus.busy       = (r_state != S_IDLE);
    io_bus.resp_valid = (r_state == S_RESP);
    io_bus.resp_rdata = r_rdata;
    io_bus.resp_err   = r_err;
  end

  // Request capture, wait counter and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= 4'd0;
      r_write <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_write <= io_bus.req_write;
        r_addr  <= io_bus.req_addr;
        r_wdata <= io_bus.req_wdata;
        r_cnt   <= CNT_INIT;
      end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end

      if (w_enter_resp) begin
        r_err   <= w_err;
        r_rdata <= (w_err || w_op_write) ? 32'd0 : w_rd_word;
      end else if ((r_state == S_RESP) && io_bus.resp_ready) begin
        r_err   <= 1'b0;
        r_rdata <= 32'd0;
      end
    end
  end

  // Storage: a store commits only on the edge entering RESP, so a reset
  // during WAIT drops it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wvld <= '0;
    end else if (w_we) begin
      r_wvld[w_idx] <= 1'b1;
      r_mem[w_idx]  <= w_op_wdata;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (LATENCY=2/DEPTH=1024 and LATENCY=0/DEPTH=16)
// driven by directed transactions, checked every cycle against a transaction-level model.
module tb_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Bench-side drive values and observed outputs, indexed by instance
  logic        t_vld [2];
  logic        t_wr  [2];
  logic [31:0] t_addr[2];
  logic [31:0] t_wdata[2];
  logic        t_rrdy[2];

  logic        o_rdy [2];
  logic        o_busy[2];
  logic        o_vld [2];
  logic [31:0] o_rdata[2];
  logic        o_err [2];

  mem_responder_if if0 ();
  mem_responder_if if1 ();

  assign if0.req_valid  = t_vld[0];
  assign if0.req_write  = t_wr[0];
  assign if0.req_addr   = t_addr[0];
  assign if0.req_wdata  = t_wdata[0];
  assign if0.resp_ready = t_rrdy[0];
  assign if1.req_valid  = t_vld[1];
  assign if1.req_write  = t_wr[1];
  assign if1.req_addr   = t_addr[1];
  assign if1.req_wdata  = t_wdata[1];
  assign if1.resp_ready = t_rrdy[1];

  assign o_rdy[0]   = if0.req_ready;
  assign o_busy[0]  = if0.busy;
  assign o_vld[0]   = if0.resp_valid;
  assign o_rdata[0] = if0.resp_rdata;
  assign o_err[0]   = if0.resp_err;
  assign o_rdy[1]   = if1.req_ready;
  assign o_busy[1]  = if1.busy;
  assign o_vld[1]   = if1.resp_valid;
  assign o_rdata[1] = if1.resp_rdata;
  assign o_err[1]   = if1.resp_err;

  mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u_dut0 (.clk(clk), .rst(rst), .io_bus(if0.slave));
  mem_responder #(.DEPTH_WORDS(16),   .LATENCY(0)) u_dut1 (.clk(clk), .rst(rst), .io_bus(if1.slave));

  function automatic int depth_of(input int ch);
    return (ch == 0) ? 1024 : 16;
  endfunction

  function automatic int lat_of(input int ch);
    return (ch == 0) ? 2 : 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // One outstanding transaction per instance; its result is due at edge
  // (accept edge + LATENCY), and it retires on the first later edge with resp_ready.
  logic [31:0] m_mem [int unsigned];
  bit          m_active  [2];
  bit          m_resolved[2];
  int          m_ready_at[2];
  bit          m_wr      [2];
  logic [31:0] m_addr    [2];
  logic [31:0] m_wdata   [2];
  logic [31:0] m_rdata   [2];
  bit          m_err     [2];
  int          m_cyc  = 0;
  bit          m_live = 0;

  task automatic model_step(input int ch);
    longint unsigned a;
    int unsigned key;
    if (rst) begin
      m_active[ch]   = 0;
      m_resolved[ch] = 0;
      return;
    end
    if (m_active[ch] && m_resolved[ch] && t_rrdy[ch]) begin
      m_active[ch]   = 0;
      m_resolved[ch] = 0;
    end else if (!m_active[ch] && t_vld[ch]) begin
      m_active[ch]   = 1;
      m_resolved[ch] = 0;
      m_wr[ch]       = t_wr[ch];
      m_addr[ch]     = t_addr[ch];
      m_wdata[ch]    = t_wdata[ch];
      m_ready_at[ch] = m_cyc + lat_of(ch);
    end
    if (m_active[ch] && !m_resolved[ch] && m_cyc == m_ready_at[ch]) begin
      m_resolved[ch] = 1;
      a   = 64'(m_addr[ch]);
      key = 32'(ch) * 4096 + 32'(m_addr[ch] >> 2);
      if ((a % 4) != 0 || a >= 64'(4 * depth_of(ch))) begin
        m_err[ch]   = 1;
        m_rdata[ch] = 32'd0;
      end else if (m_wr[ch]) begin
        m_err[ch]   = 0;
        m_rdata[ch] = 32'd0;
        m_mem[key]  = m_wdata[ch];
      end else begin
        m_err[ch]   = 0;
        m_rdata[ch] = m_mem.exists(key) ? m_mem[key] : 32'd0;
      end
    end
  endtask

  always @(posedge clk) begin
    if (rst) m_mem.delete();
    for (int ch = 0; ch < 2; ch++) model_step(ch);
    m_cyc++;
    m_live = 1;
  end

  // Every-cycle comparison, away from the active edge
  always @(negedge clk) begin
    if (m_live) begin
      for (int ch = 0; ch < 2; ch++) begin
        bit ev;
        ev = m_active[ch] && m_resolved[ch];
        chk($sformatf("u%0d req_ready", ch),  32'(o_rdy[ch]),  32'(!m_active[ch]));
        chk($sformatf("u%0d busy", ch),       32'(o_busy[ch]), 32'(m_active[ch]));
        chk($sformatf("u%0d resp_valid", ch), 32'(o_vld[ch]),  32'(ev));
        chk($sformatf("u%0d resp_rdata", ch), o_rdata[ch],     ev ? m_rdata[ch] : 32'd0);
        chk($sformatf("u%0d resp_err", ch),   32'(o_err[ch]),  32'(ev && m_err[ch]));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  // Issue one request, optionally hold off resp_ready, then handshake.
  // Scrambles the req_* inputs right after accept to show they were captured.
  task automatic txn(input int ch, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                     input int hold, input logic [31:0] exp_rdata, input bit exp_err, input string name);
    int lat;
    bit got;
    @(negedge clk);
    #1;
    t_vld[ch] = 1'b1; t_wr[ch] = wr; t_addr[ch] = addr; t_wdata[ch] = wdata; t_rrdy[ch] = 1'b0;
    lat = 0;
    got = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(posedge clk);
      #1;
      lat++;
      if (k == 0) begin
        t_vld[ch] = 1'b0; t_wr[ch] = ~wr; t_addr[ch] = ~addr; t_wdata[ch] = ~wdata;
      end
      if (o_vld[ch]) got = 1;
    end
    chk({name, " resp seen"}, 32'(got), 32'd1);
    chk({name, " latency"}, 32'(lat), 32'(lat_of(ch) + 1));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
    end
    chk({name, " rdata"}, o_rdata[ch], exp_rdata);
    chk({name, " err"}, 32'(o_err[ch]), 32'(exp_err));
    t_rrdy[ch] = 1'b1;
    @(posedge clk);
    #1;
    t_rrdy[ch] = 1'b0;
    chk({name, " req_ready after handshake"}, 32'(o_rdy[ch]), 32'd1);
  endtask

  initial begin
    for (int ch = 0; ch < 2; ch++) begin
      t_vld[ch] = 1'b0; t_wr[ch] = 1'b0; t_addr[ch] = 32'd0; t_wdata[ch] = 32'd0; t_rrdy[ch] = 1'b0;
    end
    // A request presented during reset must be ignored
    t_vld[0] = 1'b1; t_addr[0] = 32'h10;
    repeat (2) @(posedge clk);
    #1;
    chk("reset req_ready", 32'(o_rdy[0]), 32'd1);
    chk("reset busy", 32'(o_busy[0]), 32'd0);
    chk("reset resp_valid", 32'(o_vld[0]), 32'd0);
    t_vld[0] = 1'b0;
    rst = 1'b0;

    // Instance 0: LATENCY=2, DEPTH_WORDS=1024
    txn(0, 1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 32'h0,         0, "store 0x10");
    txn(0, 0, 32'h0000_0010, 32'h0,         0, 32'hDEAD_BEEF, 0, "load 0x10");
    txn(0, 1, 32'h0000_0012, 32'h1234_5678, 0, 32'h0,         1, "misaligned store");
    txn(0, 0, 32'h0000_0010, 32'h0,         0, 32'hDEAD_BEEF, 0, "load after misaligned");
    txn(0, 0, 32'h0000_1000, 32'h0,         0, 32'h0,         1, "load 0x1000 oor");
    txn(0, 0, 32'h0000_0FFC, 32'h0,         0, 32'h0,         0, "load 0xFFC");
    txn(0, 1, 32'h0000_0FFC, 32'hA5A5_0001, 0, 32'h0,         0, "store 0xFFC");
    txn(0, 0, 32'h0000_0FFC, 32'h0,         0, 32'hA5A5_0001, 0, "load 0xFFC back");
    txn(0, 1, 32'h0000_1010, 32'hBAD0_BAD0, 0, 32'h0,         1, "store oor alias");
    txn(0, 0, 32'h0000_0010, 32'h0,         5, 32'hDEAD_BEEF, 0, "backpressured load");

    // Reset while a store waits: nothing commits, storage clears
    @(negedge clk);
    #1;
    t_vld[0] = 1'b1; t_wr[0] = 1'b1; t_addr[0] = 32'h20; t_wdata[0] = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    t_vld[0] = 1'b0;
    chk("store waiting busy", 32'(o_busy[0]), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort busy", 32'(o_busy[0]), 32'd0);
    chk("abort req_ready", 32'(o_rdy[0]), 32'd1);
    chk("abort resp_valid", 32'(o_vld[0]), 32'd0);
    chk("abort resp_rdata", o_rdata[0], 32'd0);
    txn(0, 0, 32'h0000_0020, 32'h0, 0, 32'h0, 0, "load aborted 0x20");
    txn(0, 0, 32'h0000_0010, 32'h0, 0, 32'h0, 0, "load 0x10 after reset");

    // Instance 1: LATENCY=0, DEPTH_WORDS=16
    txn(1, 1, 32'h0000_003C, 32'h1111_2222, 0, 32'h0,         0, "L0 store 0x3C");
    txn(1, 0, 32'h0000_003C, 32'h0,         2, 32'h1111_2222, 0, "L0 load 0x3C");
    txn(1, 0, 32'h0000_0040, 32'h0,         0, 32'h0,         1, "L0 load 0x40 oor");
    txn(1, 1, 32'h0000_003E, 32'h9999_9999, 0, 32'h0,         1, "L0 misaligned store");
    txn(1, 0, 32'h0000_003C, 32'h0,         0, 32'h1111_2222, 0, "L0 load 0x3C again");

    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Safety net: never hang
  initial begin
    #200000;
    $display("FAIL global timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
